// File: rtl/fetch_unit_pkg.sv
// ==========================================================================
// fetch_unit_pkg : shared fetch-stage types and constants
// Rev 1.0
// ==========================================================================
`default_nettype none

package fetch_unit_pkg;

  typedef enum logic [1:0] {
    FETCH        = 2'd0,
    WAIT_RESOLVE = 2'd1,
    DRAIN        = 2'd2
  } fetch_state_e;

  // ADDI x0,x0,0 with the two always-11 opcode bits stripped
  localparam logic [29:0] c_NOP_INSTR  = 30'h4;
  localparam int          c_FIFO_DEPTH = 2;

endpackage

`default_nettype wire

// File: rtl/fetch_unit_if.sv
// ==========================================================================
// fetch_unit_if : instruction-memory request/response bus
// Rev 1.0
// ==========================================================================
`default_nettype none

interface fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            im_req;
  logic [XLEN-1:0] im_addr;
  logic            im_ack;
  logic [31:0]     im_rdata;

  modport master (output im_req, im_addr, input im_ack, im_rdata);
  modport slave  (input im_req, im_addr, output im_ack, im_rdata);
endinterface

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ==========================================================================
// fetch_fifo : 2-entry response buffer of {pc, instr}
// Rev 1.0
// ==========================================================================
`default_nettype none

module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int WIDTH = 62
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] r_mem [c_FIFO_DEPTH];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == 2'(c_FIFO_DEPTH));
  assign empty     = (r_count == 2'd0);
  assign count     = r_count;
  assign head_data = r_mem[r_rd_ptr];

  // A push into a full FIFO is only accepted when the head leaves at the same edge
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_do_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_do_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !flush) r_mem[r_wr_ptr] <= push_data;
  end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ==========================================================================
// fetch_unit : PC generation, memory bus, response FIFO and D register
// Rev 1.0
// ==========================================================================
`default_nettype none

module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic                clk,
  input  logic                reset_n,
  fetch_unit_if.master        im,
  input  logic                stall_D,
  input  logic                stall_M,
  input  logic                jb_D,
  input  logic                resolve_E,
  input  logic                redirect_E,
  input  logic [XLEN-1:0]     target_E,
  output logic [29:0]         instr_D,
  output logic [XLEN-1:0]     pc_D,
  output logic                valid_D
);

  localparam int c_ENTRY_W = XLEN + 30;

  fetch_state_e    r_state, w_state_next;
  logic            r_req, w_req_next;
  logic [XLEN-1:0] r_pc, w_pc_next;
  logic            r_discard, w_discard_next;
  logic [XLEN-1:0] r_resume, w_resume_next;
  logic [29:0]     r_instr_d, w_instr_d_next;
  logic [XLEN-1:0] r_pc_d, w_pc_d_next;
  logic            r_valid_d, w_valid_d_next;

  logic                 w_adv, w_resp, w_keep, w_jb, w_bypass;
  logic                 w_fifo_push, w_fifo_pop, w_fifo_full, w_fifo_empty;
  logic [1:0]           w_fifo_count;
  logic [2:0]           w_occ_next;
  logic                 w_can_issue;
  logic [c_ENTRY_W-1:0] w_fifo_head;
  logic [XLEN-1:0]      w_target;
  logic                 w_unused;

  assign w_adv  = ~stall_D & ~stall_M;
  assign w_resp = r_req & im.im_ack;
  assign w_keep = w_resp & ~r_discard & (r_state == FETCH);
  assign w_jb   = (r_state == FETCH) & jb_D & w_adv;

  assign w_fifo_pop  = w_adv & ~w_fifo_empty & ~w_jb;
  assign w_bypass    = w_adv & w_fifo_empty & w_keep & ~w_jb;
  assign w_fifo_push = w_keep & ~w_bypass & ~w_jb;

  // A new request needs a guaranteed FIFO slot for its response after this edge
  assign w_occ_next  = {1'b0, w_fifo_count} + {2'b0, w_fifo_push} - {2'b0, w_fifo_pop};
  assign w_can_issue = (w_occ_next < 3'd2);

  assign w_target = redirect_E ? {target_E[XLEN-1:2], 2'b00} : r_resume;

  fetch_fifo #(
    .WIDTH (c_ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (w_jb),
    .push      (w_fifo_push),
    .pop       (w_fifo_pop),
    .push_data ({r_pc, im.im_rdata[31:2]}),
    .head_data (w_fifo_head),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty),
    .count     (w_fifo_count)
  );

  always_comb begin
    w_state_next   = r_state;
    w_req_next     = r_req;
    w_pc_next      = r_pc;
    w_discard_next = r_discard;
    w_resume_next  = r_resume;
    case (r_state)
      FETCH: begin
        if (w_jb) begin
          w_state_next   = WAIT_RESOLVE;
          w_resume_next  = r_pc_d + XLEN'(4);
          w_discard_next = r_req & ~im.im_ack;
          w_req_next     = r_req & ~im.im_ack;
        end else if (!r_req || im.im_ack) begin
          if (w_resp) w_pc_next = r_pc + XLEN'(4);
          w_req_next = w_can_issue;
        end
      end
      WAIT_RESOLVE: begin
        if (w_resp) begin
          w_req_next     = 1'b0;
          w_discard_next = 1'b0;
        end
        if (resolve_E) begin
          if (r_req && !im.im_ack) begin
            // Address must stay put until the stale response returns
            w_state_next  = DRAIN;
            w_resume_next = w_target;
          end else begin
            w_state_next   = FETCH;
            w_pc_next      = w_target;
            w_req_next     = 1'b1;
            w_discard_next = 1'b0;
          end
        end
      end
      DRAIN: begin
        if (w_resp) begin
          w_state_next   = FETCH;
          w_pc_next      = r_resume;
          w_req_next     = 1'b1;
          w_discard_next = 1'b0;
        end
      end
      default: w_state_next = FETCH;
    endcase
  end

  always_comb begin
    w_instr_d_next = r_instr_d;
    w_pc_d_next    = r_pc_d;
    w_valid_d_next = r_valid_d;
    if (w_adv) begin
      if (w_fifo_pop) begin
        {w_pc_d_next, w_instr_d_next} = w_fifo_head;
        w_valid_d_next = 1'b1;
      end else if (w_bypass) begin
        w_pc_d_next    = r_pc;
        w_instr_d_next = im.im_rdata[31:2];
        w_valid_d_next = 1'b1;
      end else begin
        w_instr_d_next = c_NOP_INSTR;
        w_valid_d_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= FETCH;
      r_req     <= 1'b0;
      r_pc      <= RESET_VECTOR;
      r_discard <= 1'b0;
      r_resume  <= '0;
      r_instr_d <= c_NOP_INSTR;
      r_pc_d    <= '0;
      r_valid_d <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_req     <= w_req_next;
      r_pc      <= w_pc_next;
      r_discard <= w_discard_next;
      r_resume  <= w_resume_next;
      r_instr_d <= w_instr_d_next;
      r_pc_d    <= w_pc_d_next;
      r_valid_d <= w_valid_d_next;
    end
  end

  assign im.im_req  = r_req;
  assign im.im_addr = r_pc;
  assign instr_D    = r_instr_d;
  assign pc_D       = r_pc_d;
  assign valid_D    = r_valid_d;

  assign w_unused = &{1'b0, w_fifo_full, im.im_rdata[1:0], target_E[1:0]};

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ==========================================================================
// tb_fetch_unit : scoreboard bench for fetch_unit with directed scenarios
// Rev 1.0
// ==========================================================================
`default_nettype none

module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall_D, stall_M, jb_D, resolve_E, redirect_E;
  logic [31:0] target_E;
  logic [29:0] instr_D;
  logic [31:0] pc_D;
  logic        valid_D;

  fetch_unit_if #(.XLEN(32)) im_bus ();

  fetch_unit #(
    .XLEN         (32),
    .RESET_VECTOR (32'h0)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .im         (im_bus.master),
    .stall_D    (stall_D),
    .stall_M    (stall_M),
    .jb_D       (jb_D),
    .resolve_E  (resolve_E),
    .redirect_E (redirect_E),
    .target_E   (target_E),
    .instr_D    (instr_D),
    .pc_D       (pc_D),
    .valid_D    (valid_D)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          ack_delay = 0;
  int          ack_budget = 0;
  int          wait_cnt = 0;
  logic [31:0] exp_q [$];
  logic        adv_q = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[29:0] ^ 30'h2AAA5555, 2'b11};
  endfunction

  function automatic logic [29:0] exp_instr(input logic [31:0] a);
    logic [31:0] w;
    w = mem_word(a);
    return w[31:2];
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves the DUT in reset at a falling edge with the responder re-armed
  task automatic start_test(input int delay, input int budget);
    @(negedge clk);
    #2;
    reset_n = 1'b0; stall_D = 1'b0; stall_M = 1'b0; jb_D = 1'b0;
    resolve_E = 1'b0; redirect_E = 1'b0; target_E = '0;
    neg(2);
    ack_delay  = delay;
    ack_budget = budget;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Memory responder: acks after ack_delay waiting cycles while budget lasts
  initial begin
    im_bus.im_ack   = 1'b0;
    im_bus.im_rdata = '0;
    forever begin
      @(negedge clk);
      if (im_bus.im_ack) begin
        ack_budget--;
        wait_cnt = 0;
      end
      im_bus.im_ack = 1'b0;
      if (!reset_n) begin
        wait_cnt = 0;
      end else if (im_bus.im_req) begin
        if (wait_cnt >= ack_delay && ack_budget > 0) begin
          im_bus.im_ack   = 1'b1;
          im_bus.im_rdata = mem_word(im_bus.im_addr);
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  always @(posedge clk) adv_q <= reset_n && !stall_D && !stall_M;

  // Monitor: every D load is either the next expected instruction or a NOP bubble
  initial begin
    logic [31:0] p;
    forever begin
      @(negedge clk);
      if (reset_n && adv_q) begin
        if (valid_D) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: got pc %0h expected none", pc_D);
          end else begin
            p = exp_q.pop_front();
            check("sb_pc", 64'(pc_D), 64'(p));
            check("sb_instr", 64'(instr_D), 64'(exp_instr(p)));
          end
        end else begin
          check("bubble_nop", 64'(instr_D), 64'h4);
        end
      end
    end
  end

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: got %0d pending expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    reset_n = 1'b0; stall_D = 1'b0; stall_M = 1'b0; jb_D = 1'b0;
    resolve_E = 1'b0; redirect_E = 1'b0; target_E = '0;
    neg(2);
    #1;
    check("rst_req", 64'(im_bus.im_req), 64'h0);
    check("rst_addr", 64'(im_bus.im_addr), 64'h0);
    check("rst_instr", 64'(instr_D), 64'h4);
    check("rst_pc", 64'(pc_D), 64'h0);
    check("rst_valid", 64'(valid_D), 64'h0);

    // Straight-line stream, zero-wait ack
    start_test(0, 8);
    for (int i = 0; i < 8; i++) exp_q.push_back(32'(4 * i));
    release_reset();
    for (int i = 0; i < 4; i++) begin
      neg(1);
      check("seq_req", 64'(im_bus.im_req), 64'h1);
      check("seq_addr", 64'(im_bus.im_addr), 64'(4 * i));
    end
    neg(16);
    check_drained("seq_drained");

    // D stalled for three cycles: FIFO fills, request stops, nothing lost
    start_test(0, 10);
    for (int i = 0; i < 10; i++) exp_q.push_back(32'(4 * i));
    release_reset();
    neg(3);
    stall_D = 1'b1;
    neg(2);
    check("stall_req_drop", 64'(im_bus.im_req), 64'h0);
    check("stall_pc_hold", 64'(pc_D), 64'h4);
    check("stall_valid_hold", 64'(valid_D), 64'h1);
    neg(1);
    stall_D = 1'b0;
    neg(20);
    check_drained("stall_drained");

    // Taken jump at 0x10 to 0x103; a stray resolve in FETCH is ignored
    start_test(0, 9);
    foreach (exp_q[i]) exp_q.delete();
    exp_q.push_back(32'h0);   exp_q.push_back(32'h4);   exp_q.push_back(32'h8);
    exp_q.push_back(32'hC);   exp_q.push_back(32'h10);  exp_q.push_back(32'h100);
    exp_q.push_back(32'h104); exp_q.push_back(32'h108);
    release_reset();
    neg(3);
    resolve_E = 1'b1; redirect_E = 1'b1; target_E = 32'h200;
    neg(1);
    resolve_E = 1'b0; redirect_E = 1'b0; target_E = '0;
    neg(2);
    check("jb_pc_d", 64'(pc_D), 64'h10);
    jb_D = 1'b1;
    neg(1);
    jb_D = 1'b0;
    neg(1);
    resolve_E = 1'b1; redirect_E = 1'b1; target_E = 32'h103;
    neg(1);
    resolve_E = 1'b0; redirect_E = 1'b0; target_E = '0;
    check("redir_req", 64'(im_bus.im_req), 64'h1);
    check("redir_addr", 64'(im_bus.im_addr), 64'h100);
    neg(15);
    check_drained("redir_drained");

    // Not-taken branch at 0x10, jb_D presented while stalled first
    start_test(0, 10);
    for (int i = 0; i < 5; i++) exp_q.push_back(32'(4 * i));
    exp_q.push_back(32'h14); exp_q.push_back(32'h18); exp_q.push_back(32'h1C);
    release_reset();
    neg(6);
    jb_D = 1'b1; stall_M = 1'b1;
    neg(2);
    check("nt_pc_hold", 64'(pc_D), 64'h10);
    stall_M = 1'b0;
    neg(1);
    jb_D = 1'b0;
    resolve_E = 1'b1; redirect_E = 1'b0; target_E = 32'h300;
    neg(1);
    resolve_E = 1'b0; target_E = '0;
    check("nt_req", 64'(im_bus.im_req), 64'h1);
    check("nt_addr", 64'(im_bus.im_addr), 64'h14);
    neg(15);
    check_drained("nt_drained");

    // Slow memory: resolve before the stale ack forces a drain
    start_test(5, 3);
    exp_q.push_back(32'h0); exp_q.push_back(32'h40);
    release_reset();
    neg(7);
    check("drain_pc_d", 64'(pc_D), 64'h0);
    jb_D = 1'b1;
    neg(1);
    jb_D = 1'b0;
    resolve_E = 1'b1; redirect_E = 1'b1; target_E = 32'h40;
    neg(1);
    resolve_E = 1'b0; redirect_E = 1'b0; target_E = '0;
    neg(1);
    check("drain_hold_req", 64'(im_bus.im_req), 64'h1);
    check("drain_hold_addr", 64'(im_bus.im_addr), 64'h4);
    neg(3);
    check("drain_new_req", 64'(im_bus.im_req), 64'h1);
    check("drain_new_addr", 64'(im_bus.im_addr), 64'h40);
    neg(15);
    check_drained("drain_drained");

    // Asynchronous reset with a request in flight, then a clean restart
    start_test(0, 100);
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    release_reset();
    neg(1);
    check("boot_req", 64'(im_bus.im_req), 64'h1);
    check("boot_addr", 64'(im_bus.im_addr), 64'h0);
    neg(3);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_req", 64'(im_bus.im_req), 64'h0);
    check("arst_addr", 64'(im_bus.im_addr), 64'h0);
    check("arst_instr", 64'(instr_D), 64'h4);
    check("arst_pc", 64'(pc_D), 64'h0);
    check("arst_valid", 64'(valid_D), 64'h0);
    check_drained("arst_pre_drained");
    neg(2);
    ack_budget = 2;
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    release_reset();
    neg(1);
    check("restart_addr", 64'(im_bus.im_addr), 64'h0);
    neg(12);
    check_drained("restart_drained");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath and PC width.
REQ-002 SHALL have parameter RESET_VECTOR, default 0, meaning first fetch address after reset.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports im_req output 1, im_addr output XLEN, im_ack input 1, im_rdata input 32, forming the instruction-memory request/response bus.
REQ-006 SHALL have ports stall_D input 1, stall_M input 1, the pipeline hold requests.
REQ-007 SHALL have port jb_D input 1, meaning the instruction currently in D is a jump or branch.
REQ-008 SHALL have ports resolve_E input 1, redirect_E input 1, target_E input XLEN, meaning the jump/branch is resolved in E, taken flag, and taken target.
REQ-009 SHALL have outputs instr_D 30 (instruction bits 31:2), pc_D XLEN, and valid_D 1 for the D register.

Function
REQ-010 SHALL keep at most one bus request outstanding; im_req and im_addr held stable from assertion until the im_ack cycle, inclusive.
REQ-011 SHALL treat im_rdata as valid only in a cycle with im_req=1 and im_ack=1; ack in the same cycle as req is legal.
REQ-012 SHALL buffer responses in a 2-entry FIFO of {pc, instr}; a request is issued only when FIFO occupancy plus outstanding count is below 2, or when D pops in the same cycle.
REQ-013 SHALL write the response directly into the D register on the ack edge when the FIFO is empty and D advances, giving 1-cycle ack-to-valid_D latency; otherwise the response is pushed into the FIFO.
REQ-014 SHALL sustain one instruction per cycle with zero-wait ack and no stalls; im_addr increments by 4 after each ack.
REQ-015 SHALL advance D (load from FIFO head or bypass) only when stall_D=0 and stall_M=0; when stalled, instr_D, pc_D and valid_D hold.
REQ-016 SHALL present instr_D=30'h4 (ADDI x0,x0,0) with valid_D=0 whenever D advances with no instruction available.
REQ-017 SHALL implement FSM states FETCH, WAIT_RESOLVE, DRAIN.
REQ-018 FETCH -> WAIT_RESOLVE when jb_D=1 and D advances; on that edge, flush the FIFO, load a bubble into D, capture resume_pc = pc_D+4, and mark any outstanding response as discard.
REQ-019 WAIT_RESOLVE SHALL issue no new requests; a response acked while in this state is discarded.
REQ-020 On resolve_E=1 in WAIT_RESOLVE: fetch PC becomes target_E (bits 1:0 forced 0) if redirect_E=1, else resume_pc; go to DRAIN if a discard response is still outstanding, else FETCH.
REQ-021 DRAIN SHALL discard exactly the one outstanding response, then go to FETCH and request the new PC on the cycle following that ack.
REQ-022 resolve_E in FETCH or DRAIN SHALL be ignored.
REQ-023 jb_D=1 while D is stalled SHALL have no effect until the cycle D advances.
REQ-024 Simultaneous FIFO push and pop SHALL keep occupancy unchanged; push when full SHALL be impossible by REQ-012.
REQ-025 im_rdata bits 1:0 SHALL be dropped; no compressed-instruction support.

Reset
REQ-026 While reset_n=0: im_req=0, im_addr=RESET_VECTOR, FIFO empty, outstanding/discard flags 0, state FETCH, instr_D=30'h4, pc_D=0, valid_D=0.
REQ-027 im_req SHALL assert on the first rising edge after reset_n deasserts, addressing RESET_VECTOR.
REQ-028 Reset asserted mid-transaction SHALL abandon the request; a late im_ack after reset release without a new request SHALL be ignored.

Structure
REQ-029 The fetch state enum and the NOP constant 30'h4 SHALL live in the shared core package.
REQ-030 The 2-entry FIFO SHALL be a sub-module named fetch_fifo (push/pop/full/empty/count, async reset); FSM, PC and D register stay in fetch_unit.

Verification
REQ-031 Reset release, ack same cycle, no stalls -> im_addr 0,4,8,... in consecutive cycles; valid_D=1 from the second cycle after the first ack, pc_D increments by 4.
REQ-032 stall_D=1 for 3 cycles with zero-wait ack -> D holds; FIFO fills to 2; im_req drops; no instruction lost or duplicated after release.
REQ-033 jb_D at pc_D=0x10, resolve_E with redirect_E=1, target_E=0x103 -> next im_addr 0x100; no instruction from 0x14+ reaches valid_D.
REQ-034 Same as 033 with redirect_E=0 -> next im_addr 0x14.
REQ-035 Ack delayed 5 cycles, jb_D then resolve_E before the ack -> DRAIN; the late response discarded; following request to the target.
REQ-036 reset_n pulsed low with a request outstanding -> all outputs at reset values asynchronously; fetch restarts at RESET_VECTOR.
